// File: rtl/imem_responder.sv
// Instruction-memory responder: single-outstanding fetch with programmable latency and a host load port.
// Define IMEM_OOB_HALT_EN to return the HALT word (16'hF000) instead of NOP for out-of-range fetches.
module imem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH       = 256,
    parameter int LATENCY     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [INSTR_WIDTH-1:0] rsp_instr,
    output logic [ADDR_WIDTH-1:0]  rsp_addr,
    output logic                   rsp_err,
    input  logic                   ld_en,
    input  logic [ADDR_WIDTH-1:0]  ld_addr,
    input  logic [INSTR_WIDTH-1:0] ld_data,
    output logic                   busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int                CNT_W    = 4;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATENCY - 1);

`ifdef IMEM_OOB_HALT_EN
    localparam logic [INSTR_WIDTH-1:0] OOB_WORD = INSTR_WIDTH'(16'hF000);
`else
    localparam logic [INSTR_WIDTH-1:0] OOB_WORD = '0;
`endif

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   req_in_range;
    logic                   ld_in_range;

    // Widened to int so the range test stays meaningful when DEPTH == 2**ADDR_WIDTH.
    assign req_in_range = int'(req_addr) < DEPTH;
    assign ld_in_range  = int'(ld_addr) < DEPTH;

    // NOTE: the array has no reset so program contents survive a core reset.
    always_ff @(posedge clk) begin
        if (ld_en && ld_in_range) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // NOTE: non-blocking reads of mem here see the pre-write word when a load hits the same address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_addr  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        rsp_addr  <= req_addr;
                        rsp_err   <= !req_in_range;
                        rsp_instr <= req_in_range ? mem[req_addr] : OOB_WORD;
                        cnt       <= CNT_INIT;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (LATENCY == 1) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Leaving on the cycle the counter would hit zero keeps total latency at LATENCY.
                    if (cnt <= CNT_W'(1)) begin
                        cnt       <= '0;
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus randomized fetches against a memory model.
module tb_imem_responder;

    localparam int AW      = 8;
    localparam int IW      = 16;
    localparam int A_DEPTH = 200;
    localparam int A_LAT   = 2;
    localparam int B_DEPTH = 256;
    localparam int B_LAT   = 1;

`ifdef IMEM_OOB_HALT_EN
    localparam logic [IW-1:0] OOB_WORD = 16'hF000;
`else
    localparam logic [IW-1:0] OOB_WORD = 16'h0000;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err, a_ld_en, a_busy;
    logic [AW-1:0] a_req_addr, a_rsp_addr, a_ld_addr;
    logic [IW-1:0] a_rsp_instr, a_ld_data;
    logic          b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_ld_en, b_busy;
    logic [AW-1:0] b_req_addr, b_rsp_addr, b_ld_addr;
    logic [IW-1:0] b_rsp_instr, b_ld_data;

    imem_responder #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(A_DEPTH), .LATENCY(A_LAT)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_instr(a_rsp_instr),
        .rsp_addr(a_rsp_addr), .rsp_err(a_rsp_err),
        .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data), .busy(a_busy)
    );

    imem_responder #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(B_DEPTH), .LATENCY(B_LAT)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_instr(b_rsp_instr),
        .rsp_addr(b_rsp_addr), .rsp_err(b_rsp_err),
        .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data), .busy(b_busy)
    );

    int errors = 0;
    int checks = 0;
    logic [IW-1:0] model_a [256];
    logic [IW-1:0] model_b [256];

    task automatic ld_a(input logic [AW-1:0] addr, input logic [IW-1:0] data);
        a_ld_en = 1'b1; a_ld_addr = addr; a_ld_data = data;
        @(posedge clk); #1;
        a_ld_en = 1'b0;
        if (int'(addr) < A_DEPTH) model_a[addr] = data;
    endtask

    task automatic ld_b(input logic [AW-1:0] addr, input logic [IW-1:0] data);
        b_ld_en = 1'b1; b_ld_addr = addr; b_ld_data = data;
        @(posedge clk); #1;
        b_ld_en = 1'b0;
        if (int'(addr) < B_DEPTH) model_b[addr] = data;
    endtask

    // One fetch on instance A; optional same-cycle load (coll) and a load to the same address during WAIT.
    task automatic fetch_a(input logic [AW-1:0] addr, input int stall, input bit coll,
                           input logic [IW-1:0] coll_data, input bit wr_wait, input string tag);
        logic [IW-1:0] exp_w;
        logic          exp_e;
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1) begin
            errors++; $display("FAIL %s req_ready before request: got %b want 1", tag, a_req_ready);
        end
        exp_e = int'(addr) >= A_DEPTH;
        exp_w = exp_e ? OOB_WORD : model_a[addr];
        a_req_valid = 1'b1; a_req_addr = addr; a_rsp_ready = 1'b0;
        if (coll) begin
            a_ld_en = 1'b1; a_ld_addr = addr; a_ld_data = coll_data;
        end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        a_req_addr  = AW'($urandom);
        a_ld_en     = 1'b0;
        if (coll && !exp_e) model_a[addr] = coll_data;
        for (int c = 1; c <= A_LAT; c++) begin
            @(negedge clk);
            a_ld_en = 1'b0;
            if (c == 1 && wr_wait && A_LAT > 1) begin
                a_ld_en = 1'b1; a_ld_addr = addr; a_ld_data = ~exp_w;
                if (!exp_e) model_a[addr] = ~exp_w;
            end
            checks++;
            if (a_rsp_valid !== (c == A_LAT)) begin
                errors++; $display("FAIL %s rsp_valid timing cycle %0d: got %b want %b", tag, c, a_rsp_valid, c == A_LAT);
            end
        end
        a_ld_en = 1'b0;
        for (int s = 0; s < ((stall > 1) ? stall : 1); s++) begin
            if (s > 0) @(negedge clk);
            checks++;
            if (a_rsp_valid !== 1'b1 || a_rsp_instr !== exp_w || a_rsp_addr !== addr || a_rsp_err !== exp_e) begin
                errors++;
                $display("FAIL %s response hold %0d: got v=%b instr=%h addr=%h err=%b want v=1 instr=%h addr=%h err=%b",
                         tag, s, a_rsp_valid, a_rsp_instr, a_rsp_addr, a_rsp_err, exp_w, addr, exp_e);
            end
            checks++;
            if (a_req_ready !== 1'b0 || a_busy !== 1'b1) begin
                errors++; $display("FAIL %s busy/req_ready in RESP: got busy=%b ready=%b want 1/0", tag, a_busy, a_req_ready);
            end
        end
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after handshake: got v=%b ready=%b busy=%b want 0/1/0", tag, a_rsp_valid, a_req_ready, a_busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_instr !== '0 || a_rsp_addr !== '0 ||
            a_rsp_err !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: got ready=%b v=%b instr=%h addr=%h err=%b busy=%b want 1 0 0000 00 0 0",
                     a_req_ready, a_rsp_valid, a_rsp_instr, a_rsp_addr, a_rsp_err, a_busy);
        end
        checks++;
        if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0 || b_busy !== 1'b0) begin
            errors++; $display("FAIL reset_b: got ready=%b v=%b busy=%b want 1 0 0", b_req_ready, b_rsp_valid, b_busy);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_load_fetch;
        ld_a(8'd5, 16'h1234);
        fetch_a(8'd5, 0, 1'b0, '0, 1'b0, "load_fetch");
    endtask

    task automatic test_backpressure;
        ld_a(8'd12, 16'hC0DE);
        fetch_a(8'd12, 4, 1'b0, '0, 1'b0, "backpressure");
    endtask

    task automatic test_collision;
        ld_a(8'd7, 16'hAAAA);
        fetch_a(8'd7, 0, 1'b1, 16'h5555, 1'b0, "collision_old");
        fetch_a(8'd7, 0, 1'b0, '0, 1'b0, "collision_new");
    endtask

    task automatic test_write_during_wait;
        ld_a(8'd9, 16'h0F0F);
        fetch_a(8'd9, 1, 1'b0, '0, 1'b1, "wait_write_pending");
        fetch_a(8'd9, 0, 1'b0, '0, 1'b0, "wait_write_after");
    endtask

    task automatic test_out_of_range;
        ld_a(8'd122, 16'h1122);
        ld_a(8'd50, 16'h3344);
        ld_a(8'd199, 16'h5566);
        ld_a(8'd250, 16'h7777);
        fetch_a(8'd250, 0, 1'b0, '0, 1'b0, "oob_250");
        fetch_a(8'd200, 0, 1'b0, '0, 1'b0, "oob_200");
        fetch_a(8'd199, 0, 1'b0, '0, 1'b0, "last_in_range");
        fetch_a(8'd122, 0, 1'b0, '0, 1'b0, "no_alias_122");
        fetch_a(8'd50, 0, 1'b0, '0, 1'b0, "no_alias_50");
    endtask

    task automatic test_reset_midflight;
        ld_a(8'd33, 16'hBEEF);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_addr = 8'd33; a_rsp_ready = 1'b0;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b1 || a_req_ready !== 1'b0 || a_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midflight in WAIT: got busy=%b ready=%b v=%b want 1 0 0", a_busy, a_req_ready, a_rsp_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (a_rsp_valid !== 1'b0 || a_busy !== 1'b0 || a_req_ready !== 1'b1 || a_rsp_err !== 1'b0 || a_rsp_instr !== '0) begin
            errors++;
            $display("FAIL midflight after reset: got v=%b busy=%b ready=%b err=%b instr=%h want 0 0 1 0 0000",
                     a_rsp_valid, a_busy, a_req_ready, a_rsp_err, a_rsp_instr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL midflight stale response %0d: got v=%b want 0", i, a_rsp_valid);
            end
        end
        fetch_a(8'd33, 0, 1'b0, '0, 1'b0, "retained_33");
        fetch_a(8'd5, 0, 1'b0, '0, 1'b0, "retained_5");
    endtask

    task automatic test_random;
        for (int i = 0; i < A_DEPTH; i++) ld_a(AW'(i), IW'($urandom));
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) ld_a(AW'($urandom_range(0, 255)), IW'($urandom));
            fetch_a(AW'($urandom_range(0, 255)), int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                    IW'($urandom), $urandom_range(0, 3) == 0, "random");
        end
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] addrs [10];
        logic [IW-1:0] exp_q [$];
        int acc_cyc [10];
        int idx, nrsp, cyc;
        for (int i = 0; i < 10; i++) begin
            addrs[i] = AW'($urandom_range(0, 255));
            ld_b(addrs[i], IW'($urandom));
        end
        idx = 0; nrsp = 0; cyc = 0;
        b_rsp_ready = 1'b1;
        while (nrsp < 10 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (b_rsp_valid === 1'b1) begin
                checks++;
                if (nrsp >= idx || b_rsp_instr !== exp_q[nrsp] || b_rsp_addr !== addrs[nrsp] ||
                    b_rsp_err !== 1'b0 || cyc != acc_cyc[nrsp] + B_LAT) begin
                    errors++;
                    $display("FAIL b2b response %0d: got instr=%h addr=%h err=%b cyc=%0d", nrsp, b_rsp_instr,
                             b_rsp_addr, b_rsp_err, cyc);
                end
                nrsp++;
            end
            if (b_req_ready === 1'b1 && idx < 10) begin
                b_req_valid = 1'b1; b_req_addr = addrs[idx];
                exp_q.push_back(model_b[addrs[idx]]);
                acc_cyc[idx] = cyc;
                if (idx > 0) begin
                    checks++;
                    if (acc_cyc[idx] - acc_cyc[idx-1] != B_LAT + 1) begin
                        errors++;
                        $display("FAIL b2b spacing %0d: got %0d want %0d", idx, acc_cyc[idx] - acc_cyc[idx-1], B_LAT + 1);
                    end
                end
                idx++;
            end else begin
                b_req_valid = 1'b0;
            end
        end
        b_req_valid = 1'b0;
        b_rsp_ready = 1'b0;
        checks++;
        if (nrsp != 10) begin
            errors++; $display("FAIL b2b completion: got %0d responses want 10", nrsp);
        end
    endtask

    initial begin
        reset = 1'b1;
        a_req_valid = 1'b0; a_req_addr = '0; a_rsp_ready = 1'b0; a_ld_en = 1'b0; a_ld_addr = '0; a_ld_data = '0;
        b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b0; b_ld_en = 1'b0; b_ld_addr = '0; b_ld_data = '0;
        test_reset;
        test_load_fetch;
        test_backpressure;
        test_collision;
        test_write_during_wait;
        test_out_of_range;
        test_reset_midflight;
        test_random;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
